// File: rtl/note_key_conditioner.sv
// Key front end: 2-flop sync, per-key debounce, priority resolve and press/hold/release FSM.
// Optional KEY_LEGATO_EN: switch notes directly while held instead of enforcing a release gap.
module note_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RELEASE_CYCLES  = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_raw,
    output logic [7:0] note,
    output logic       play,
    output logic       note_strobe,
    output logic [7:0] key_stable
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int RLW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RLW-1:0] GAP_LOAD = RLW'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        RELEASE
    } state_t;

    logic [7:0]     syncMeta_q;
    logic [7:0]     keySync_q;
    logic [DBW-1:0] dbCount_q [8];
    logic [DBW-1:0] dbCount_d [8];
    logic [7:0]     keyStable_q;
    logic [7:0]     keyStable_d;
    logic [7:0]     sel;
    state_t         state_q;
    logic [7:0]     note_q;
    logic           play_q;
    logic           strobe_q;
    logic [RLW-1:0] gap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta_q <= '0;
            keySync_q  <= '0;
        end else begin
            syncMeta_q <= key_raw;
            keySync_q  <= syncMeta_q;
        end
    end

    // A key only flips after DEBOUNCE_CYCLES consecutive differing samples; any bounce restarts the count.
    always_comb begin
        keyStable_d = keyStable_q;
        for (int i = 0; i < 8; i++) begin
            dbCount_d[i] = '0;
            if (keySync_q[i] != keyStable_q[i]) begin
                if (dbCount_q[i] == DB_LAST) begin
                    keyStable_d[i] = ~keyStable_q[i];
                end else begin
                    dbCount_d[i] = dbCount_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyStable_q <= '0;
            for (int i = 0; i < 8; i++) begin
                dbCount_q[i] <= '0;
            end
        end else begin
            keyStable_q <= keyStable_d;
            for (int i = 0; i < 8; i++) begin
                dbCount_q[i] <= dbCount_d[i];
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < 8; i++) begin
            if (keyStable_q[i]) begin
                sel = 8'b1 << i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            note_q   <= '0;
            play_q   <= 1'b0;
            strobe_q <= 1'b0;
            gap_q    <= '0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel != '0) begin
                        note_q   <= sel;
                        play_q   <= 1'b1;
                        strobe_q <= 1'b1;
                        state_q  <= HELD;
                    end
                end
                HELD: begin
`ifdef KEY_LEGATO_EN
                    if (sel == '0) begin
                        note_q  <= '0;
                        play_q  <= 1'b0;
                        gap_q   <= GAP_LOAD;
                        state_q <= RELEASE;
                    end else if (sel != note_q && !strobe_q) begin
                        // Holding off one cycle after a strobe keeps strobes from running back to back.
                        note_q   <= sel;
                        strobe_q <= 1'b1;
                    end
`else
                    if ((keyStable_q & note_q) == '0) begin
                        note_q  <= '0;
                        play_q  <= 1'b0;
                        gap_q   <= GAP_LOAD;
                        state_q <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    if (gap_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign note        = note_q;
    assign play        = play_q;
    assign note_strobe = strobe_q;
    assign key_stable  = keyStable_q;

endmodule

// File: tb/tb_note_key_conditioner.sv
// Self-checking bench for note_key_conditioner (DEBOUNCE_CYCLES=4, RELEASE_CYCLES=3), honours KEY_LEGATO_EN.
module tb_note_key_conditioner;

   logic       clk;
   logic       rst_n;
   logic [7:0] keyRaw;
   logic [7:0] note;
   logic       play;
   logic       noteStrobe;
   logic [7:0] keyStable;

   int tests    = 0;
   int failures = 0;
   int cycle    = 0;
   int edgeZero = 0;
   int strobeSeen = 0;

   typedef struct {
      logic [7:0] note;
      int         lo;
      int         hi;
      string      name;
   } ev_t;

   typedef struct {
      logic [7:0] keyRaw;
      logic       expChange;
      logic [7:0] expNote;
      logic [7:0] expStable;
   } vec_t;

   ev_t  sbQ[$];
   vec_t vecs[8];
   logic [7:0] prevNote = '0;

   note_key_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .RELEASE_CYCLES (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_raw    (keyRaw),
      .note       (note),
      .play       (play),
      .note_strobe(noteStrobe),
      .key_stable (keyStable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Every note change must match the next scheduled event; strobe must mark each new non-zero note.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevNote = '0;
      end else begin
         logic changed;
         changed = (note != prevNote);
         if (noteStrobe) strobeSeen++;
         tests++;
         if ($countones(note) > 1 || play != (note != 8'h00)) begin
            failures++;
            $display("[TB] FAIL invariant: note=%h play=%b at cycle %0d", note, play, cycle);
         end
         tests++;
         if (noteStrobe != (changed && note != 8'h00)) begin
            failures++;
            $display("[TB] FAIL strobe: note_strobe=%b required %b at cycle %0d", noteStrobe,
                     (changed && note != 8'h00), cycle);
         end
         if (changed) begin
            tests++;
            if (sbQ.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected change: note=%h (was %h) at cycle %0d, none expected",
                        note, prevNote, cycle);
            end else begin
               ev_t e;
               e = sbQ.pop_front();
               if (note != e.note || cycle < e.lo || cycle > e.hi) begin
                  failures++;
                  $display("[TB] FAIL %s: note=%h at cycle %0d, required note=%h in cycles %0d..%0d",
                           e.name, note, cycle, e.note, e.lo, e.hi);
               end
            end
         end
         prevNote = note;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] v);
      @(posedge clk);
      #1 keyRaw = v;
      edgeZero = cycle;
   endtask

   task automatic expectNote(input string name, input logic [7:0] n, input int lo, input int hi);
      ev_t e;
      e.note = n;
      e.lo   = edgeZero + lo;
      e.hi   = edgeZero + hi;
      e.name = name;
      sbQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] expNote, input logic [7:0] expStable);
      tests++;
      if (note != expNote || play != (expNote != 8'h00) || keyStable != expStable || noteStrobe != 1'b0) begin
         failures++;
         $display("[TB] FAIL %s: note=%h play=%b key_stable=%h strobe=%b, required note=%h play=%b key_stable=%h strobe=0",
                  name, note, play, keyStable, noteStrobe, expNote, (expNote != 8'h00), expStable);
      end
      tests++;
      if (sbQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL %s timeout: %0d expected events not seen, next note=%h", name, sbQ.size(),
                  sbQ[0].note);
         sbQ.delete();
      end
   endtask

   initial begin
      vecs[0] = '{8'h80, 1'b1, 8'h80, 8'h80};
      vecs[1] = '{8'h00, 1'b1, 8'h00, 8'h00};
      vecs[2] = '{8'h12, 1'b1, 8'h10, 8'h12};
      vecs[3] = '{8'h10, 1'b0, 8'h10, 8'h10};
      vecs[4] = '{8'h00, 1'b1, 8'h00, 8'h00};
      vecs[5] = '{8'h04, 1'b1, 8'h04, 8'h04};
`ifdef KEY_LEGATO_EN
      vecs[6] = '{8'h84, 1'b1, 8'h80, 8'h84};
`else
      vecs[6] = '{8'h84, 1'b0, 8'h04, 8'h84};
`endif
      vecs[7] = '{8'h00, 1'b1, 8'h00, 8'h00};

      rst_n  = 1'b0;
      keyRaw = 8'h00;
      waitCycles(3);
      #1 checkOutput("reset", 8'h00, 8'h00);
      rst_n = 1'b1;
      waitCycles(8);
      checkOutput("idle after reset", 8'h00, 8'h00);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].keyRaw);
         if (vecs[i].expChange) expectNote($sformatf("vec%0d", i), vecs[i].expNote, 7, 7);
         waitCycles(14);
         checkOutput($sformatf("vec%0d steady", i), vecs[i].expNote, vecs[i].expStable);
      end

      applyStimulus(8'h40);
      expectNote("gap first", 8'h40, 7, 7);
      waitCycles(14);
      checkOutput("gap held", 8'h40, 8'h40);
      applyStimulus(8'h08);
`ifdef KEY_LEGATO_EN
      expectNote("legato switch", 8'h08, 7, 7);
`else
      expectNote("gap release", 8'h00, 7, 7);
      expectNote("gap relatch", 8'h08, 10, 12);
`endif
      waitCycles(16);
      checkOutput("gap second", 8'h08, 8'h08);
      applyStimulus(8'h00);
      expectNote("gap off", 8'h00, 7, 7);
      waitCycles(14);
      checkOutput("gap idle", 8'h00, 8'h00);

      for (int i = 0; i < 10; i++) begin
         applyStimulus((i % 2 == 0) ? 8'h20 : 8'h00);
         waitCycles(1);
      end
      applyStimulus(8'h20);
      expectNote("bounce settle", 8'h20, 7, 7);
      waitCycles(14);
      checkOutput("bounce held", 8'h20, 8'h20);
      applyStimulus(8'h00);
      expectNote("bounce off", 8'h00, 7, 7);
      waitCycles(14);
      checkOutput("bounce idle", 8'h00, 8'h00);

      applyStimulus(8'h80);
      expectNote("pre-reset press", 8'h80, 7, 7);
      waitCycles(10);
      checkOutput("pre-reset held", 8'h80, 8'h80);
      @(posedge clk);
      #3 rst_n = 1'b0;
      keyRaw = 8'h00;
      #1 checkOutput("mid-reset", 8'h00, 8'h00);
      begin
         int strobeBefore;
         strobeBefore = strobeSeen;
         waitCycles(3);
         #1 rst_n = 1'b1;
         waitCycles(12);
         tests++;
         if (strobeSeen != strobeBefore) begin
            failures++;
            $display("[TB] FAIL reset release strobe: %0d strobes seen, required 0", strobeSeen - strobeBefore);
         end
      end
      checkOutput("after reset", 8'h00, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
